// File: rtl/ew_pkg.sv
// Shared types for the EW decision controller and link action executor.
package ew_pkg;

  // Controller state codes published by the decision controller.
  typedef enum logic [2:0] {
    CtrlMonitor  = 3'd0,
    CtrlValidate = 3'd1,
    CtrlJammed   = 3'd2,
    CtrlBlackout = 3'd3,
    CtrlRecovery = 3'd4
  } ctrl_state_e;

  typedef enum logic [2:0] {
    StRecover,
    StActive,
    StMute,
    StTune,
    StSettle,
    StAnnounce,
    StIsolate
  } exec_state_e;

  localparam int unsigned ChanWidth   = 2;
  localparam int unsigned HopSeqWidth = 6;
  localparam int unsigned BeaconWidth = HopSeqWidth + ChanWidth;

  // Codes 5-7 behave as MONITOR, so only VALIDATE/RECOVERY/BLACKOUT block a hop.
  function automatic logic hop_allowed(logic [2:0] st);
    return !(st == CtrlValidate || st == CtrlRecovery || st == CtrlBlackout);
  endfunction

endpackage

// File: rtl/ew_timer.sv
// Loadable down-counter shared by the executor's guard, settle, timeout and recover phases.
module ew_timer #(
  parameter int unsigned CntWidth   = 8,
  parameter int unsigned ResetValue = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic [CntWidth-1:0] load_value,
  output logic                done
);

  logic [CntWidth-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= CntWidth'(ResetValue);
    end else if (load) begin
      cnt_q <= load_value;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/link_action_executor.sv
// Executes controller channel/isolation decisions as guarded hop sequences on the RF front end.
// Optional hop beacon (ANNOUNCE state, hop_seq) enabled by defining HOP_ANNOUNCE_EN.
module link_action_executor
  import ew_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES   = 4,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TUNE_TIMEOUT   = 64,
  parameter int unsigned RECOVER_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2:0]             fsm_state,
  input  logic [ChanWidth-1:0]   channel_sel,
  input  logic                   synth_ack,
  input  logic                   beacon_ready,
  output logic                   synth_req,
  output logic [ChanWidth-1:0]   synth_ch,
  output logic                   tx_enable,
  output logic                   rx_isolate,
  output logic [ChanWidth-1:0]   active_channel,
  output logic                   beacon_valid,
  output logic [BeaconWidth-1:0] beacon_data,
  output logic                   exec_busy,
  output logic                   tune_fault
);

  localparam int unsigned MaxGs    = (GUARD_CYCLES > SETTLE_CYCLES) ? GUARD_CYCLES : SETTLE_CYCLES;
  localparam int unsigned MaxTr    = (TUNE_TIMEOUT > RECOVER_CYCLES) ? TUNE_TIMEOUT : RECOVER_CYCLES;
  localparam int unsigned MaxCyc   = (MaxGs > MaxTr) ? MaxGs : MaxTr;
  localparam int unsigned CntWidth = $clog2(MaxCyc + 1);

  // Loads taken on an edge use N-1 so the phase ends exactly N edges later.
  localparam logic [CntWidth-1:0] GuardLoad   = CntWidth'(GUARD_CYCLES - 1);
  localparam logic [CntWidth-1:0] SettleLoad  = CntWidth'(SETTLE_CYCLES - 1);
  localparam logic [CntWidth-1:0] TimeoutLoad = CntWidth'(TUNE_TIMEOUT - 1);
  localparam logic [CntWidth-1:0] RecoverLoad = CntWidth'(RECOVER_CYCLES - 1);

  exec_state_e          state_q, state_d;
  logic                 tx_enable_q, tx_enable_d;
  logic                 rx_isolate_q, rx_isolate_d;
  logic                 synth_req_q, synth_req_d;
  logic [ChanWidth-1:0] synth_ch_q, synth_ch_d;
  logic [ChanWidth-1:0] active_q, active_d;
  logic [ChanWidth-1:0] target_q, target_d;
  logic                 fault_q, fault_d;
  logic                 blk_pend_q, blk_pend_d;
  logic                 busy_q;
  logic                 to_isolate;
  logic                 tmr_load;
  logic [CntWidth-1:0]  tmr_value;
  logic                 tmr_done;
  logic                 blackout;

`ifdef HOP_ANNOUNCE_EN
  logic                   bvalid_q, bvalid_d;
  logic [BeaconWidth-1:0] bdata_q, bdata_d;
  logic [HopSeqWidth-1:0] hop_seq_q, hop_seq_d;
`endif

  assign blackout = (fsm_state == CtrlBlackout);

  ew_timer #(
    .CntWidth   (CntWidth),
    .ResetValue (RECOVER_CYCLES)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_value (tmr_value),
    .done       (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    tx_enable_d  = tx_enable_q;
    rx_isolate_d = rx_isolate_q;
    synth_req_d  = synth_req_q;
    synth_ch_d   = synth_ch_q;
    active_d     = active_q;
    target_d     = target_q;
    fault_d      = fault_q;
    blk_pend_d   = blk_pend_q;
    to_isolate   = 1'b0;
    tmr_load     = 1'b0;
    tmr_value    = '0;
`ifdef HOP_ANNOUNCE_EN
    bvalid_d     = bvalid_q;
    bdata_d      = bdata_q;
    hop_seq_d    = hop_seq_q;
`endif
    unique case (state_q)
      StRecover: begin
        if (tmr_done) begin
          state_d     = StActive;
          tx_enable_d = 1'b1;
        end
      end
      StActive: begin
        if (blackout) begin
          to_isolate = 1'b1;
        end else if (hop_allowed(fsm_state) && channel_sel != active_q) begin
          target_d    = channel_sel;
          state_d     = StMute;
          tx_enable_d = 1'b0;
          tmr_load    = 1'b1;
          tmr_value   = GuardLoad;
        end
      end
      StMute: begin
        if (blackout) begin
          to_isolate = 1'b1;
        end else if (tmr_done) begin
          state_d     = StTune;
          synth_req_d = 1'b1;
          synth_ch_d  = target_q;
          blk_pend_d  = 1'b0;
          tmr_load    = 1'b1;
          tmr_value   = TimeoutLoad;
        end
      end
      StTune: begin
        // Blackout is remembered but not acted on until the handshake closes.
        if (blackout) blk_pend_d = 1'b1;
        if (synth_ack) begin
          synth_req_d = 1'b0;
          active_d    = target_q;
          if (blk_pend_q || blackout) begin
            to_isolate = 1'b1;
          end else begin
            state_d   = StSettle;
            tmr_load  = 1'b1;
            tmr_value = SettleLoad;
          end
        end else if (tmr_done) begin
          synth_req_d = 1'b0;
          fault_d     = 1'b1;
          if (blk_pend_q || blackout) begin
            to_isolate = 1'b1;
          end else begin
            state_d     = StActive;
            tx_enable_d = 1'b1;
          end
        end
      end
      StSettle: begin
        if (blackout) begin
          to_isolate = 1'b1;
        end else if (tmr_done) begin
          tx_enable_d = 1'b1;
`ifdef HOP_ANNOUNCE_EN
          state_d  = StAnnounce;
          bvalid_d = 1'b1;
          bdata_d  = {hop_seq_q, active_q};
`else
          state_d  = StActive;
`endif
        end
      end
`ifdef HOP_ANNOUNCE_EN
      StAnnounce: begin
        if (blackout) begin
          to_isolate = 1'b1;
        end else if (beacon_ready) begin
          bvalid_d  = 1'b0;
          hop_seq_d = hop_seq_q + 1'b1;
          state_d   = StActive;
        end
      end
`endif
      StIsolate: begin
        if (!blackout) begin
          state_d      = StRecover;
          rx_isolate_d = 1'b0;
          tmr_load     = 1'b1;
          tmr_value    = RecoverLoad;
        end
      end
      default: begin
        state_d   = StRecover;
        tmr_load  = 1'b1;
        tmr_value = RecoverLoad;
      end
    endcase

    if (to_isolate) begin
      state_d      = StIsolate;
      tx_enable_d  = 1'b0;
      rx_isolate_d = 1'b1;
      blk_pend_d   = 1'b0;
`ifdef HOP_ANNOUNCE_EN
      bvalid_d     = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StRecover;
      tx_enable_q  <= 1'b0;
      rx_isolate_q <= 1'b0;
      synth_req_q  <= 1'b0;
      synth_ch_q   <= '0;
      active_q     <= '0;
      target_q     <= '0;
      fault_q      <= 1'b0;
      blk_pend_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tx_enable_q  <= tx_enable_d;
      rx_isolate_q <= rx_isolate_d;
      synth_req_q  <= synth_req_d;
      synth_ch_q   <= synth_ch_d;
      active_q     <= active_d;
      target_q     <= target_d;
      fault_q      <= fault_d;
      blk_pend_q   <= blk_pend_d;
      busy_q       <= (state_d != StActive);
    end
  end

`ifdef HOP_ANNOUNCE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bvalid_q  <= 1'b0;
      bdata_q   <= '0;
      hop_seq_q <= '0;
    end else begin
      bvalid_q  <= bvalid_d;
      bdata_q   <= bdata_d;
      hop_seq_q <= hop_seq_d;
    end
  end

  assign beacon_valid = bvalid_q;
  assign beacon_data  = bdata_q;
`else
  logic unused_beacon_ready;
  assign unused_beacon_ready = beacon_ready;
  assign beacon_valid        = 1'b0;
  assign beacon_data         = '0;
`endif

  assign synth_req      = synth_req_q;
  assign synth_ch       = synth_ch_q;
  assign tx_enable      = tx_enable_q;
  assign rx_isolate     = rx_isolate_q;
  assign active_channel = active_q;
  assign exec_busy      = busy_q;
  assign tune_fault     = fault_q;

endmodule

// File: tb/tb_link_action_executor.sv
// Directed self-checking bench for link_action_executor (default parameters).
module tb_link_action_executor;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] fsm_state;
  logic [1:0] channel_sel;
  logic       synth_ack;
  logic       beacon_ready;
  logic       synth_req;
  logic [1:0] synth_ch;
  logic       tx_enable;
  logic       rx_isolate;
  logic [1:0] active_channel;
  logic       beacon_valid;
  logic [7:0] beacon_data;
  logic       exec_busy;
  logic       tune_fault;

  int total = 0;
  int bad   = 0;
  logic seen_bv = 1'b0;

  always #5 clk = ~clk;

  link_action_executor dut (
    .clk            (clk),
    .reset          (reset),
    .fsm_state      (fsm_state),
    .channel_sel    (channel_sel),
    .synth_ack      (synth_ack),
    .beacon_ready   (beacon_ready),
    .synth_req      (synth_req),
    .synth_ch       (synth_ch),
    .tx_enable      (tx_enable),
    .rx_isolate     (rx_isolate),
    .active_channel (active_channel),
    .beacon_valid   (beacon_valid),
    .beacon_data    (beacon_data),
    .exec_busy      (exec_busy),
    .tune_fault     (tune_fault)
  );

  always @(posedge clk) if (beacon_valid) seen_bv <= 1'b1;

  // Observed vector: {tx, iso, req, sch[1:0], act[1:0], bv, bdata[7:0], busy, fault}
  typedef struct {
    string       name;
    int          n;
    logic [2:0]  fsm;
    logic [1:0]  ch;
    logic        ack;
    logic        rdy;
    logic [17:0] exp;
  } row_t;

  row_t rows[$];

  function automatic row_t mk(string name, int n, logic [2:0] fsm, logic [1:0] ch, logic ack,
                              logic rdy, logic tx, logic iso, logic req, logic [1:0] sch,
                              logic [1:0] act, logic bv, logic [7:0] bd, logic busy,
                              logic fault);
    row_t r;
    r.name = name; r.n = n; r.fsm = fsm; r.ch = ch; r.ack = ack; r.rdy = rdy;
    r.exp  = {tx, iso, req, sch, act, bv, bd, busy, fault};
    return r;
  endfunction

  function automatic logic [17:0] obs();
    return {tx_enable, rx_isolate, synth_req, synth_ch, active_channel, beacon_valid,
            beacon_data, exec_busy, tune_fault};
  endfunction

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] f, input logic [1:0] c, input logic a, input logic r);
    fsm_state = f; channel_sel = c; synth_ack = a; beacon_ready = r;
  endtask

  initial begin
    reset = 1'b1;
    drive(3'd0, 2'd0, 1'b0, 1'b0);

    //              name        n  fsm ch ack rdy tx iso req sch act bv bd    busy flt
    rows.push_back(mk("rst",     0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    rows.push_back(mk("rec8",    8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0));
    rows.push_back(mk("rec9",    1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    rows.push_back(mk("validate",2, 1, 2, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    rows.push_back(mk("recovery",1, 4, 2, 0, 0, 1, 0, 0, 0, 0, 0, 8'h00, 0, 0));
    rows.push_back(mk("mute",    1, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0));
    rows.push_back(mk("guard3",  3, 2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 1, 0));
    rows.push_back(mk("req",     1, 2, 2, 0, 0, 0, 0, 1, 2, 0, 0, 8'h00, 1, 0));
    rows.push_back(mk("midhop",  2, 2, 3, 0, 0, 0, 0, 1, 2, 0, 0, 8'h00, 1, 0));
    rows.push_back(mk("ack",     1, 2, 3, 1, 0, 0, 0, 0, 2, 2, 0, 8'h00, 1, 0));
    rows.push_back(mk("settle15",15,2, 2, 0, 0, 0, 0, 0, 2, 2, 0, 8'h00, 1, 0));
`ifdef HOP_ANNOUNCE_EN
    rows.push_back(mk("beacon",  1, 2, 2, 0, 0, 1, 0, 0, 2, 2, 1, 8'h02, 1, 0));
    rows.push_back(mk("hold",    3, 2, 2, 0, 0, 1, 0, 0, 2, 2, 1, 8'h02, 1, 0));
    rows.push_back(mk("accept",  1, 2, 2, 0, 1, 1, 0, 0, 2, 2, 0, 8'h02, 0, 0));
    rows.push_back(mk("hop2",    1, 0, 1, 0, 0, 0, 0, 0, 2, 2, 0, 8'h02, 1, 0));
    rows.push_back(mk("req2",    4, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 8'h02, 1, 0));
    rows.push_back(mk("ack2",    1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 8'h02, 1, 0));
    rows.push_back(mk("beacon2", 16,0, 1, 0, 0, 1, 0, 0, 1, 1, 1, 8'h05, 1, 0));
    rows.push_back(mk("accept2", 1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 0, 8'h05, 0, 0));
`else
    rows.push_back(mk("settled", 1, 2, 2, 0, 0, 1, 0, 0, 2, 2, 0, 8'h00, 0, 0));
    rows.push_back(mk("idle",    3, 2, 2, 0, 1, 1, 0, 0, 2, 2, 0, 8'h00, 0, 0));
    rows.push_back(mk("hop2",    1, 0, 1, 0, 0, 0, 0, 0, 2, 2, 0, 8'h00, 1, 0));
    rows.push_back(mk("req2",    4, 0, 1, 0, 0, 0, 0, 1, 1, 2, 0, 8'h00, 1, 0));
    rows.push_back(mk("ack2",    1, 0, 1, 1, 0, 0, 0, 0, 1, 1, 0, 8'h00, 1, 0));
    rows.push_back(mk("done2",   16,0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 8'h00, 0, 0));
`endif

    adv(2);
    reset = 1'b0;

    foreach (rows[i]) begin
      drive(rows[i].fsm, rows[i].ch, rows[i].ack, rows[i].rdy);
      adv(rows[i].n);
      total++;
      if (obs() !== rows[i].exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", rows[i].name, obs(), rows[i].exp);
      end
    end

    // Synth timeout, then automatic retry toward the same channel.
    drive(3'd0, 2'd3, 1'b0, 1'b0);
    adv(1);  chk("to_mute_tx", {7'd0, tx_enable}, 8'd0);
    adv(4);  chk("to_req", {7'd0, synth_req}, 8'd1);
    adv(63); chk("to_req_held", {7'd0, synth_req}, 8'd1);
             chk("to_nofault_yet", {7'd0, tune_fault}, 8'd0);
    adv(1);  chk("to_fault", {7'd0, tune_fault}, 8'd1);
             chk("to_req_drop", {7'd0, synth_req}, 8'd0);
             chk("to_act_kept", {6'd0, active_channel}, 8'd1);
             chk("to_tx_on", {7'd0, tx_enable}, 8'd1);
    adv(1);  chk("to_retry", {6'd0, tx_enable, exec_busy}, 8'd1);
    adv(4);  chk("to_retry_req", {5'd0, synth_req, synth_ch}, 8'h07);
    synth_ack = 1'b1;
    adv(1);  chk("to_retry_act", {6'd0, active_channel}, 8'd3);
             chk("to_fault_sticky", {7'd0, tune_fault}, 8'd1);
    synth_ack = 1'b0;

    // Blackout while settling drops the beacon and forces a timed recovery.
    adv(5);
    fsm_state = 3'd3;
    adv(1);  chk("bs_iso", {5'd0, tx_enable, rx_isolate, beacon_valid}, 8'h02);
    adv(20); chk("bs_held", {5'd0, tx_enable, rx_isolate, beacon_valid}, 8'h02);
             chk("bs_act", {6'd0, active_channel}, 8'd3);
    fsm_state = 3'd0;
    adv(1);  chk("bs_release", {6'd0, tx_enable, rx_isolate}, 8'd0);
    adv(7);  chk("bs_rec7", {6'd0, tx_enable, exec_busy}, 8'd1);
    adv(1);  chk("bs_rec8", {6'd0, tx_enable, exec_busy}, 8'd2);

    // Blackout during TUNE is deferred until the ack closes the handshake.
    channel_sel = 2'd0;
    adv(5);  chk("bt_req", {7'd0, synth_req}, 8'd1);
    fsm_state = 3'd3;
    adv(3);  chk("bt_req_held", {6'd0, synth_req, rx_isolate}, 8'h02);
    synth_ack = 1'b1;
    adv(1);  chk("bt_iso", {5'd0, synth_req, rx_isolate, tx_enable}, 8'h02);
             chk("bt_act", {6'd0, active_channel}, 8'd0);
    synth_ack = 1'b0;
    fsm_state = 3'd0;
    adv(1);  chk("bt_release", {7'd0, rx_isolate}, 8'd0);
    adv(8);  chk("bt_tx", {7'd0, tx_enable}, 8'd1);

    // One more hop: the dropped beacon must not have advanced hop_seq.
    drive(3'd2, 2'd2, 1'b0, 1'b0);
    adv(5);  synth_ack = 1'b1;
    adv(1);  synth_ack = 1'b0;
    adv(15); chk("h3_settle", {7'd0, tx_enable}, 8'd0);
    adv(1);  chk("h3_tx", {7'd0, tx_enable}, 8'd1);
`ifdef HOP_ANNOUNCE_EN
             chk("h3_beacon", beacon_data, 8'h0A);
             chk("h3_bv", {7'd0, beacon_valid}, 8'd1);
    beacon_ready = 1'b1;
    adv(1);  chk("h3_accept", {7'd0, beacon_valid}, 8'd0);
`else
    adv(2);  chk("never_bv", {7'd0, seen_bv}, 8'd0);
             chk("bdata_zero", beacon_data, 8'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
